// File: rtl/bus_datapath_seq_pkg.sv
// Shared encodings for the bus datapath and its micro-sequencer.
package bus_dp_pkg;

  // Instruction opcodes as presented on instr_op.
  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_ADDI = 2'b01,
    OP_MV   = 2'b10,
    OP_ADD  = 2'b11
  } op_e;

  // Sequencer steps: IDLE waits for an instruction, T1..T3 are the bus steps.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_e;

endpackage

// File: rtl/bus_datapath_seq_if.sv
// Instruction handshake, completion status and debug read port of the datapath.
interface bus_datapath_seq_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_op;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] instr_rs;
  logic [REG_AW-1:0] instr_rt;
  logic [WIDTH-1:0]  instr_imm;
  logic              done;
  logic              err;
  logic [REG_AW-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_data;
  logic [WIDTH-1:0]  z_data;

  // Instruction source (CPU control unit or bench).
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm, dbg_addr,
    input  instr_ready, done, err, dbg_data, z_data
  );

  // The datapath itself.
  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm, dbg_addr,
    output instr_ready, done, err, dbg_data, z_data
  );
endinterface

// File: rtl/bus_datapath_seq_ctrl.sv
// Micro-sequencer: latches one instruction per handshake and walks it through
// T-steps, emitting the bus strobes for the datapath in the top level.
module bus_dp_ctrl
  import bus_dp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 4
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [1:0]          instr_op,
  input  logic [REG_AW-1:0]   instr_rd,
  input  logic [REG_AW-1:0]   instr_rs,
  input  logic [REG_AW-1:0]   instr_rt,
  input  logic [WIDTH-1:0]    instr_imm,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                y_in,
  output logic                z_in,
  output logic                z_out,
  output logic                imm_out,
  output logic                imm_add,
  output logic [WIDTH-1:0]    imm,
  output logic                done,
  output logic                err
);

  state_e            state;
  state_e            state_next;
  op_e               op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              accept;
  logic              finish;
  logic              bad;

  function automatic logic legal(input logic [REG_AW-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // An out-of-range index decodes to no strobe at all: reads see 0, writes vanish.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_AW-1:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  assign instr_ready = (state == ST_IDLE) && clear_n;
  assign accept      = instr_ready && instr_valid;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values, independent of block order.
    if (!clear_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Instruction latch: fields are captured only at acceptance and held until retirement.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      op  <= OP_LDI;
      rd  <= '0;
      rs  <= '0;
      rt  <= '0;
      imm <= '0;
    end else if (accept) begin
      op  <= op_e'(instr_op);
      rd  <= instr_rd;
      rs  <= instr_rs;
      rt  <= instr_rt;
      imm <= instr_imm;
    end
  end

  // Retirement status, registered so done/err appear the cycle after the final step.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= finish;
      err  <= finish && bad;
    end
  end

  // Next-state and per-step strobe decode.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves one unassigned (no latch).
    state_next = state;
    reg_in     = '0;
    reg_out    = '0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    z_out      = 1'b0;
    imm_out    = 1'b0;
    imm_add    = 1'b0;
    finish     = 1'b0;
    bad        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instr_valid) state_next = ST_T1;
      end
      ST_T1: begin
        case (op)
          OP_LDI: begin
            imm_out    = 1'b1;
            reg_in     = onehot(rd);
            finish     = 1'b1;
            bad        = !legal(rd);
            state_next = ST_IDLE;
          end
          OP_MV: begin
            reg_out    = onehot(rs);
            reg_in     = onehot(rd);
            finish     = 1'b1;
            bad        = !legal(rd) || !legal(rs);
            state_next = ST_IDLE;
          end
          OP_ADDI: begin
            reg_out    = onehot(rs);
            imm_add    = 1'b1;
            z_in       = 1'b1;
            state_next = ST_T2;
          end
          default: begin
            reg_out    = onehot(rs);
            y_in       = 1'b1;
            state_next = ST_T2;
          end
        endcase
      end
      ST_T2: begin
        case (op)
          OP_ADDI: begin
            z_out      = 1'b1;
            reg_in     = onehot(rd);
            finish     = 1'b1;
            bad        = !legal(rd) || !legal(rs);
            state_next = ST_IDLE;
          end
          OP_ADD: begin
            reg_out    = onehot(rt);
            z_in       = 1'b1;
            state_next = ST_T3;
          end
          default: state_next = ST_IDLE;
        endcase
      end
      default: begin
        z_out      = 1'b1;
        reg_in     = onehot(rd);
        finish     = 1'b1;
        bad        = !legal(rd) || !legal(rs) || !legal(rt);
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath: register file, Y/Z temporaries and adder, driven by
// the bus_dp_ctrl micro-sequencer. Debug port reads any register combinationally.
module bus_datapath_seq
  import bus_dp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 4
) (
  input  logic         clock,
  input  logic         clear_n,
  bus_datapath_seq_if.slave bus
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [WIDTH-1:0]    y;
  logic [WIDTH-1:0]    z;
  logic [WIDTH-1:0]    data_bus;
  logic [WIDTH-1:0]    adder_a;
  logic [WIDTH-1:0]    sum;
  logic [WIDTH-1:0]    dbg;
  logic [WIDTH-1:0]    imm;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                y_in;
  logic                z_in;
  logic                z_out;
  logic                imm_out;
  logic                imm_add;

  bus_dp_ctrl #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_ctrl (
    .clock       (clock),
    .clear_n     (clear_n),
    .instr_valid (bus.instr_valid),
    .instr_ready (bus.instr_ready),
    .instr_op    (bus.instr_op),
    .instr_rd    (bus.instr_rd),
    .instr_rs    (bus.instr_rs),
    .instr_rt    (bus.instr_rt),
    .instr_imm   (bus.instr_imm),
    .reg_in      (reg_in),
    .reg_out     (reg_out),
    .y_in        (y_in),
    .z_in        (z_in),
    .z_out       (z_out),
    .imm_out     (imm_out),
    .imm_add     (imm_add),
    .imm         (imm),
    .done        (bus.done),
    .err         (bus.err)
  );

  // Wired-OR bus: with no source enabled (e.g. an out-of-range register) it reads 0.
  always_comb begin
    data_bus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_out[i]) data_bus |= regs[i];
    end
    if (z_out)   data_bus |= z;
    if (imm_out) data_bus |= imm;
  end

  // The adder's A side is Y, or the immediate for ADDI so it finishes in one step.
  assign adder_a = imm_add ? imm : y;
  assign sum     = adder_a + data_bus;

  // Register file write from the bus.
  always_ff @(posedge clock) begin
    // NOTE: the register file is small and flop-based, so it is cleared on reset like any other state.
    if (!clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_in[i]) regs[i] <= data_bus;
      end
    end
  end

  // Y captures the first ADD operand; Z captures the adder result.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      y <= '0;
      z <= '0;
    end else begin
      if (y_in) y <= data_bus;
      if (z_in) z <= sum;
    end
  end

  // Debug read: out-of-range indices return 0.
  always_comb begin
    dbg = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(bus.dbg_addr) == i) dbg = regs[i];
    end
  end

  assign bus.dbg_data = dbg;
  assign bus.z_data   = z;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Bench: three configurations (32/8, 8/4, 16/16) driven in lockstep from one
// stimulus stream and checked against a per-configuration reference model.
module tb_bus_datapath_seq;
  import bus_dp_pkg::*;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        valid;
  logic [1:0]  op;
  logic [3:0]  rd, rs, rt, dbg;
  logic [31:0] imm;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  bus_datapath_seq_if #(.WIDTH(32), .REG_AW(4)) if_a ();
  bus_datapath_seq_if #(.WIDTH(8),  .REG_AW(3)) if_b ();
  bus_datapath_seq_if #(.WIDTH(16), .REG_AW(4)) if_c ();

  assign if_a.instr_valid = valid;
  assign if_a.instr_op    = op;
  assign if_a.instr_rd    = rd;
  assign if_a.instr_rs    = rs;
  assign if_a.instr_rt    = rt;
  assign if_a.instr_imm   = imm;
  assign if_a.dbg_addr    = dbg;

  assign if_b.instr_valid = valid;
  assign if_b.instr_op    = op;
  assign if_b.instr_rd    = rd[2:0];
  assign if_b.instr_rs    = rs[2:0];
  assign if_b.instr_rt    = rt[2:0];
  assign if_b.instr_imm   = imm[7:0];
  assign if_b.dbg_addr    = dbg[2:0];

  assign if_c.instr_valid = valid;
  assign if_c.instr_op    = op;
  assign if_c.instr_rd    = rd;
  assign if_c.instr_rs    = rs;
  assign if_c.instr_rt    = rt;
  assign if_c.instr_imm   = imm[15:0];
  assign if_c.dbg_addr    = dbg;

  bus_datapath_seq #(.WIDTH(32), .NUM_REGS(8),  .REG_AW(4)) u_dut_a (.clock(clock), .clear_n(clear_n), .bus(if_a));
  bus_datapath_seq #(.WIDTH(8),  .NUM_REGS(4),  .REG_AW(3)) u_dut_b (.clock(clock), .clear_n(clear_n), .bus(if_b));
  bus_datapath_seq #(.WIDTH(16), .NUM_REGS(16), .REG_AW(4)) u_dut_c (.clock(clock), .clear_n(clear_n), .bus(if_c));

  // ---------------- reference model ----------------
  int cfg_w  [3] = '{32, 8, 16};
  int cfg_n  [3] = '{8, 4, 16};
  int cfg_aw [3] = '{4, 3, 4};
  longint unsigned m_reg [3][16];
  longint unsigned m_y [3];
  longint unsigned m_z [3];

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 16; i++) m_reg[c][i] = 64'd0;
      m_y[c] = 64'd0;
      m_z[c] = 64'd0;
    end
  endfunction

  function automatic int fld(int c, logic [3:0] v);
    return int'(v) & ((1 << cfg_aw[c]) - 1);
  endfunction

  function automatic longint unsigned m_read(int c, int i);
    return (i < cfg_n[c]) ? m_reg[c][i] : 64'd0;
  endfunction

  // One instruction, evaluated with plain arithmetic; returns the expected err flag.
  function automatic void model_exec(int c, logic [1:0] o, logic [3:0] d, logic [3:0] s,
                                     logic [3:0] t, logic [31:0] im, output bit e);
    longint unsigned mask = (64'd1 << cfg_w[c]) - 64'd1;
    longint unsigned val;
    int di = fld(c, d);
    int si = fld(c, s);
    int ti = fld(c, t);
    bit bd = di >= cfg_n[c];
    bit bs = si >= cfg_n[c];
    bit bt = ti >= cfg_n[c];
    case (o)
      OP_LDI: begin
        val = 64'(im) & mask;
        e   = bd;
      end
      OP_MV: begin
        val = m_read(c, si);
        e   = bd || bs;
      end
      OP_ADDI: begin
        m_z[c] = (m_read(c, si) + 64'(im)) & mask;
        val    = m_z[c];
        e      = bd || bs;
      end
      default: begin
        m_y[c] = m_read(c, si);
        m_z[c] = (m_y[c] + m_read(c, ti)) & mask;
        val    = m_z[c];
        e      = bd || bs || bt;
      end
    endcase
    if (!bd) m_reg[c][di] = val;
  endfunction

  function automatic int lat_of(logic [1:0] o);
    case (o)
      OP_ADDI: return 3;
      OP_ADD:  return 4;
      default: return 2;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg = 4'(i);
      #1;
      check({tag, "_dbg_a"}, 64'(if_a.dbg_data), m_read(0, fld(0, dbg)));
      check({tag, "_dbg_b"}, 64'(if_b.dbg_data), m_read(1, fld(1, dbg)));
      check({tag, "_dbg_c"}, 64'(if_c.dbg_data), m_read(2, fld(2, dbg)));
    end
  endtask

  task automatic scramble();
    op  = 2'($urandom);
    rd  = 4'($urandom);
    rs  = 4'($urandom);
    rt  = 4'($urandom);
    imm = $urandom;
  endtask

  // Issue one instruction, corrupt the inputs right after acceptance, wait for done.
  task automatic issue(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s,
                       input logic [3:0] t, input logic [31:0] im,
                       output int lat, output logic e_a);
    int  w;
    bit  e [3];
    logic got;
    @(negedge clock);
    op = o; rd = d; rs = s; rt = t; imm = im; valid = 1'b1;
    w = 0;
    while (!if_a.instr_ready && w < 16) begin
      @(negedge clock);
      w++;
    end
    check("ready_before_accept", 64'(if_a.instr_ready), 64'd1);
    lat = 0;
    e_a = 1'b0;
    if (!if_a.instr_ready) begin
      valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    valid = 1'b0;
    scramble();
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clock);
      lat++;
      got = if_a.done;
    end
    for (int c = 0; c < 3; c++) model_exec(c, o, d, s, t, im, e[c]);
    check("latency", 64'(lat), 64'(lat_of(o)));
    check("done_a", 64'(if_a.done), 64'd1);
    check("done_b", 64'(if_b.done), 64'd1);
    check("done_c", 64'(if_c.done), 64'd1);
    check("err_a", 64'(if_a.err), 64'(e[0]));
    check("err_b", 64'(if_b.err), 64'(e[1]));
    check("err_c", 64'(if_c.err), 64'(e[2]));
    check("z_a", 64'(if_a.z_data), m_z[0]);
    check("z_b", 64'(if_b.z_data), m_z[1]);
    check("z_c", 64'(if_c.z_data), m_z[2]);
    e_a = if_a.err;
  endtask

  // ---------------- directed vectors (32-bit / 8-register config) ----------------
  typedef struct {
    logic [1:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [31:0] imm;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  chk_idx;
    logic [31:0] exp_val;
    logic [31:0] exp_z;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic ea;
    logic [1:0] b_op [4];
    logic [3:0] b_rd [4], b_rs [4], b_rt [4];
    logic [31:0] b_imm [4];
    int   acc_cyc [4];
    int   n_acc, dones_a, dones_b, dones_c, seen_done;
    bit   e_tmp;

    vecs[0]  = '{OP_LDI,  4'd1, 4'd0,  4'd0,  32'd5,        1'b0, 2, 4'd1, 32'd5,        32'd0};
    vecs[1]  = '{OP_ADDI, 4'd2, 4'd1,  4'd0,  32'd5,        1'b0, 3, 4'd2, 32'd10,       32'd10};
    vecs[2]  = '{OP_LDI,  4'd3, 4'd0,  4'd0,  32'hFFFFFFFF, 1'b0, 2, 4'd3, 32'hFFFFFFFF, 32'd10};
    vecs[3]  = '{OP_ADDI, 4'd3, 4'd3,  4'd0,  32'd2,        1'b0, 3, 4'd3, 32'd1,        32'd1};
    vecs[4]  = '{OP_ADD,  4'd4, 4'd3,  4'd3,  32'd0,        1'b0, 4, 4'd4, 32'd2,        32'd2};
    vecs[5]  = '{OP_MV,   4'd5, 4'd4,  4'd0,  32'd0,        1'b0, 2, 4'd5, 32'd2,        32'd2};
    vecs[6]  = '{OP_LDI,  4'd9, 4'd0,  4'd0,  32'd7,        1'b1, 2, 4'd1, 32'd5,        32'd2};
    vecs[7]  = '{OP_MV,   4'd1, 4'd12, 4'd0,  32'd0,        1'b1, 2, 4'd1, 32'd0,        32'd2};
    vecs[8]  = '{OP_ADD,  4'd6, 4'd2,  4'd5,  32'd0,        1'b0, 4, 4'd6, 32'd12,       32'd12};
    vecs[9]  = '{OP_ADD,  4'd2, 4'd2,  4'd2,  32'd0,        1'b0, 4, 4'd2, 32'd20,       32'd20};
    vecs[10] = '{OP_ADDI, 4'd7, 4'd15, 4'd0,  32'd3,        1'b1, 3, 4'd7, 32'd3,        32'd3};
    vecs[11] = '{OP_ADD,  4'd8, 4'd2,  4'd2,  32'd0,        1'b1, 4, 4'd2, 32'd20,       32'd40};
    vecs[12] = '{OP_LDI,  4'd0, 4'd15, 4'd15, 32'hDEADBEEF, 1'b0, 2, 4'd0, 32'hDEADBEEF, 32'd40};
    vecs[13] = '{OP_MV,   4'd6, 4'd0,  4'd12, 32'h12345678, 1'b0, 2, 4'd6, 32'hDEADBEEF, 32'd40};

    clear_n = 1'b0;
    valid   = 1'b0;
    op = 2'd0; rd = 4'd0; rs = 4'd0; rt = 4'd0; imm = 32'd0; dbg = 4'd0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("ready_in_reset", 64'(if_a.instr_ready), 64'd0);
    clear_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(if_a.instr_ready), 64'd1);
    check("done_after_reset", 64'(if_a.done), 64'd0);
    check("z_after_reset", 64'(if_a.z_data), 64'd0);
    check_regs("reset");

    // Reset mid-ADD: load operands, start ADD r3,r1,r2, drop clear_n during T2.
    issue(OP_LDI, 4'd1, 4'd0, 4'd0, 32'd11, lat, ea);
    issue(OP_LDI, 4'd2, 4'd0, 4'd0, 32'd22, lat, ea);
    @(negedge clock);
    op = OP_ADD; rd = 4'd3; rs = 4'd1; rt = 4'd2; valid = 1'b1;
    check("ready_before_add", 64'(if_a.instr_ready), 64'd1);
    @(posedge clock);
    #1;
    valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    check("ready_low_in_clear", 64'(if_a.instr_ready), 64'd0);
    @(negedge clock);
    check("no_done_on_abort_a", 64'(if_a.done), 64'd0);
    check("no_done_on_abort_b", 64'(if_b.done), 64'd0);
    check("no_done_on_abort_c", 64'(if_c.done), 64'd0);
    clear_n = 1'b1;
    model_reset();
    #1;
    check("ready_after_abort", 64'(if_a.instr_ready), 64'd1);
    seen_done = 0;
    repeat (5) begin
      @(negedge clock);
      if (if_a.done || if_b.done || if_c.done) seen_done++;
    end
    check("no_late_done", 64'(seen_done), 64'd0);
    check("z_after_abort", 64'(if_a.z_data), 64'd0);
    check_regs("abort");

    // Table-driven directed vectors.
    for (int v = 0; v < 14; v++) begin
      issue(vecs[v].op, vecs[v].rd, vecs[v].rs, vecs[v].rt, vecs[v].imm, lat, ea);
      check($sformatf("vec%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("vec%0d_err", v), 64'(ea), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_z", v), 64'(if_a.z_data), 64'(vecs[v].exp_z));
      dbg = vecs[v].chk_idx;
      #1;
      check($sformatf("vec%0d_reg", v), 64'(if_a.dbg_data), 64'(vecs[v].exp_val));
    end
    check_regs("directed");

    // Back-to-back: valid held high, inputs scrambled while busy.
    b_op[0] = OP_LDI;  b_rd[0] = 4'd1; b_rs[0] = 4'd0; b_rt[0] = 4'd0; b_imm[0] = 32'h100;
    b_op[1] = OP_ADDI; b_rd[1] = 4'd2; b_rs[1] = 4'd1; b_rt[1] = 4'd0; b_imm[1] = 32'h23;
    b_op[2] = OP_ADD;  b_rd[2] = 4'd3; b_rs[2] = 4'd2; b_rt[2] = 4'd1; b_imm[2] = 32'h0;
    b_op[3] = OP_MV;   b_rd[3] = 4'd4; b_rs[3] = 4'd3; b_rt[3] = 4'd0; b_imm[3] = 32'h0;
    n_acc = 0; dones_a = 0; dones_b = 0; dones_c = 0;
    for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clock);
      if (if_a.done) dones_a++;
      if (if_b.done) dones_b++;
      if (if_c.done) dones_c++;
      if (n_acc < 4) begin
        valid = 1'b1;
        if (if_a.instr_ready) begin
          op = b_op[n_acc]; rd = b_rd[n_acc]; rs = b_rs[n_acc]; rt = b_rt[n_acc]; imm = b_imm[n_acc];
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end else begin
          scramble();
        end
      end else begin
        valid = 1'b0;
        scramble();
      end
    end
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++) model_exec(c, b_op[i], b_rd[i], b_rs[i], b_rt[i], b_imm[i], e_tmp);
    check("b2b_accepts", 64'(n_acc), 64'd4);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_interval%0d", i), 64'(acc_cyc[i+1] - acc_cyc[i]), 64'(lat_of(b_op[i])));
    check("b2b_dones_a", 64'(dones_a), 64'd4);
    check("b2b_dones_b", 64'(dones_b), 64'd4);
    check("b2b_dones_c", 64'(dones_c), 64'd4);
    dbg = 4'd4;
    #1;
    check("b2b_r4", 64'(if_a.dbg_data), 64'h223);
    check_regs("b2b");

    // Randomized instructions across all three configurations.
    for (int k = 0; k < 160; k++) begin
      logic [1:0]  r_op;
      logic [3:0]  r_rd, r_rs, r_rt;
      logic [31:0] r_imm;
      r_op = 2'($urandom);
      r_rd = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
      r_rs = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
      r_rt = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       r_imm = 32'hFFFFFFFF;
        1:       r_imm = 32'($urandom_range(0, 3));
        default: r_imm = $urandom;
      endcase
      issue(r_op, r_rd, r_rs, r_rt, r_imm, lat, ea);
      if (k % 20 == 19) check_regs("random");
    end
    check_regs("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
